// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and datapath width for the ALU and its control decoder.
package alu_pkg;

    localparam int W = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLT   = 4'd9,
        ALU_SLTU  = 4'd10,
        ALU_MULT  = 4'd11,
        ALU_MULTU = 4'd12,
        ALU_MADD  = 4'd13,
        ALU_DIV   = 4'd14,
        ALU_DIVU  = 4'd15
    } alu_op_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return op >= ALU_MULT;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle 64-bit multiply, multiply-accumulate and divide with the HI/LO register pair.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  alu_op_e       op,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  next_lo
);

    logic [2*W-1:0]        smul, umul, nxt;
    logic signed [W-1:0]   sa, sd, sq, sr;
    logic [W-1:0]          ud, uq, ur;
    logic                  div_zero, div_ovf;
    logic                  armed;

    always_comb begin
        smul     = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        umul     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        div_zero = b == '0;
        div_ovf  = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        // Substitute a harmless divisor for the special cases; their results are muxed in below.
        sa       = $signed(a);
        sd       = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
        sq       = sa / sd;
        sr       = sa % sd;
        ud       = div_zero ? 32'd1 : b;
        uq       = a / ud;
        ur       = a % ud;
        nxt      = op == ALU_MULT  ? smul :
                   op == ALU_MULTU ? umul :
                   op == ALU_MADD  ? {hi, lo} + smul :
                   op == ALU_DIV   ? (div_zero ? {a, 32'hFFFF_FFFF} :
                                      div_ovf  ? {32'h0, 32'h8000_0000} : {sr, sq}) :
                   op == ALU_DIVU  ? (div_zero ? {a, 32'hFFFF_FFFF} : {ur, uq}) :
                   {hi, lo};
        next_lo  = nxt[W-1:0];
    end

    // Arms half a cycle after reset release so an edge coincident with deassertion never loads.
    always_ff @(negedge clk or posedge rst)
        if (rst)
            armed <= 1'b0;
        else
            armed <= 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            {hi, lo} <= '0;
        else if (armed && is_muldiv(op))
            {hi, lo} <= nxt;

endmodule

// File: rtl/alu.sv
// alu: 32-bit combinational ALU with flags; mult/div and HI/LO live in alu_muldiv.
module alu
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [3:0]    AluCtl,
    output logic [W-1:0]  Result,
    output logic          Zero,
    output logic          Gt,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo
);

    alu_op_e      op;
    logic [W-1:0] md_lo;
    logic [4:0]   sh;

    assign op = alu_op_e'(AluCtl);
    assign sh = B[4:0];

    alu_muldiv u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .a       (A),
        .b       (B),
        .op      (op),
        .hi      (hi),
        .lo      (lo),
        .next_lo (md_lo)
    );

    always_comb begin
        Result = md_lo;
        case (op)
            ALU_ADD:  Result = A + B;
            ALU_SUB:  Result = A - B;
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_XOR:  Result = A ^ B;
            ALU_NOR:  Result = ~(A | B);
            ALU_SLL:  Result = A << sh;
            ALU_SRL:  Result = A >> sh;
            ALU_SRA:  Result = $signed(A) >>> sh;
            ALU_SLT:  Result = {31'b0, $signed(A) < $signed(B)};
            ALU_SLTU: Result = {31'b0, A < B};
            default:  Result = md_lo;
        endcase
        Zero = Result == '0;
        Gt   = $signed(A) > $signed(B);
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the alu with hand-computed expectations.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [3:0]  AluCtl;
    logic [31:0] Result, hi, lo;
    logic        Zero, Gt;
    int          tests = 0;
    int          fails = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .AluCtl (AluCtl),
        .Result (Result),
        .Zero   (Zero),
        .Gt     (Gt),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        AluCtl = op;
        A = a;
        B = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(4'd0, 32'd0, 32'd0);
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo hi=%h lo=%h exp 0/0", hi, lo); end
        tests++; if (Result !== 32'd0 || Zero !== 1'b1) begin fails++; $display("FAIL reset_zero result=%h zero=%b exp 0/1", Result, Zero); end
        rst = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_div();
        set_in(4'd14, 32'd20, 32'd5);
        tests++; if (Result !== 32'd4 || Gt !== 1'b1) begin fails++; $display("FAIL div_comb result=%h gt=%b exp 4/1", Result, Gt); end
        tick();
        tests++; if (lo !== 32'd4 || hi !== 32'd0) begin fails++; $display("FAIL div_hilo hi=%h lo=%h exp 0/4", hi, lo); end
        set_in(4'd15, 32'd20, 32'd5);
        tests++; if (Result !== 32'd4) begin fails++; $display("FAIL divu_comb result=%h exp 4", Result); end
        tick();
        tests++; if (lo !== 32'd4 || hi !== 32'd0) begin fails++; $display("FAIL divu_hilo hi=%h lo=%h exp 0/4", hi, lo); end
        set_in(4'd11, 32'd20, 32'd5);
        tick();
        tests++; if (lo !== 32'd100 || hi !== 32'd0) begin fails++; $display("FAIL mult_small hi=%h lo=%h exp 0/100", hi, lo); end
    endtask

    task automatic test_arith();
        set_in(4'd0, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'hFFFF_FFED || Zero !== 1'b0 || Gt !== 1'b0) begin fails++; $display("FAIL add result=%h zero=%b gt=%b exp ffffffed/0/0", Result, Zero, Gt); end
        set_in(4'd1, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'hFFFF_FFEB) begin fails++; $display("FAIL sub result=%h exp ffffffeb", Result); end
        set_in(4'd9, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'd1) begin fails++; $display("FAIL slt result=%h exp 1", Result); end
        set_in(4'd10, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'd0 || Zero !== 1'b1) begin fails++; $display("FAIL sltu result=%h zero=%b exp 0/1", Result, Zero); end
        set_in(4'd0, 32'hFFFF_FFFF, 32'd1);
        tests++; if (Result !== 32'd0 || Zero !== 1'b1) begin fails++; $display("FAIL add_wrap result=%h zero=%b exp 0/1", Result, Zero); end
        set_in(4'd1, 32'h8000_0000, 32'd1);
        tests++; if (Result !== 32'h7FFF_FFFF) begin fails++; $display("FAIL sub_wrap result=%h exp 7fffffff", Result); end
        set_in(4'd2, 32'd1, 32'hFFFF_FFFF);
        tests++; if (Gt !== 1'b1 || Result !== 32'd1) begin fails++; $display("FAIL and_gt result=%h gt=%b exp 1/1", Result, Gt); end
    endtask

    task automatic test_shift_logic();
        set_in(4'd8, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'hFFFF_FFF6) begin fails++; $display("FAIL sra result=%h exp fffffff6", Result); end
        set_in(4'd7, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'h7FFF_FFF6) begin fails++; $display("FAIL srl result=%h exp 7ffffff6", Result); end
        set_in(4'd6, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'hFFFF_FFD8) begin fails++; $display("FAIL sll result=%h exp ffffffd8", Result); end
        set_in(4'd5, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'h0000_0012) begin fails++; $display("FAIL nor result=%h exp 00000012", Result); end
        set_in(4'd6, 32'd1, 32'h0000_0021);
        tests++; if (Result !== 32'd2) begin fails++; $display("FAIL sll_upper_ignored result=%h exp 2", Result); end
        set_in(4'd8, 32'h8000_0000, 32'd31);
        tests++; if (Result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sra31 result=%h exp ffffffff", Result); end
        set_in(4'd3, 32'hF0F0_0000, 32'h0000_0F0F);
        tests++; if (Result !== 32'hF0F0_0F0F) begin fails++; $display("FAIL or result=%h exp f0f00f0f", Result); end
        set_in(4'd4, 32'hFFFF_0000, 32'hFF00_FF00);
        tests++; if (Result !== 32'h00FF_FF00) begin fails++; $display("FAIL xor result=%h exp 00ffff00", Result); end
    endtask

    task automatic test_mult_madd();
        set_in(4'd12, 32'hFFFF_FFEC, 32'd1);
        tick();
        tests++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFEC) begin fails++; $display("FAIL multu hi=%h lo=%h exp 0/ffffffec", hi, lo); end
        set_in(4'd11, 32'hFFFF_FFEC, 32'd1);
        tick();
        tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEC) begin fails++; $display("FAIL mult hi=%h lo=%h exp ffffffff/ffffffec", hi, lo); end
        set_in(4'd13, 32'hFFFF_FFEC, 32'd1);
        tests++; if (Result !== 32'hFFFF_FFD8) begin fails++; $display("FAIL madd_comb result=%h exp ffffffd8", Result); end
        tick();
        tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD8) begin fails++; $display("FAIL madd hi=%h lo=%h exp ffffffff/ffffffd8", hi, lo); end
        set_in(4'd0, 32'd3, 32'd4);
        tick();
        tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD8) begin fails++; $display("FAIL hold hi=%h lo=%h exp ffffffff/ffffffd8", hi, lo); end
        set_in(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin fails++; $display("FAIL multu_max hi=%h lo=%h exp fffffffe/1", hi, lo); end
    endtask

    task automatic test_div_corner();
        set_in(4'd14, 32'd7, 32'd0);
        tests++; if (Result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_comb result=%h exp ffffffff", Result); end
        tick();
        tests++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin fails++; $display("FAIL div0 hi=%h lo=%h exp 7/ffffffff", hi, lo); end
        set_in(4'd15, 32'h1234_5678, 32'd0);
        tick();
        tests++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin fails++; $display("FAIL divu0 hi=%h lo=%h exp 12345678/ffffffff", hi, lo); end
        set_in(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        tests++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin fails++; $display("FAIL div_ovf hi=%h lo=%h exp 0/80000000", hi, lo); end
        set_in(4'd14, 32'hFFFF_FFF9, 32'd2);
        tick();
        tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg hi=%h lo=%h exp ffffffff/fffffffd", hi, lo); end
        set_in(4'd15, 32'hFFFF_FFF9, 32'd2);
        tick();
        tests++; if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin fails++; $display("FAIL divu_big hi=%h lo=%h exp 1/7ffffffc", hi, lo); end
        set_in(4'd14, 32'd3, 32'd5);
        tests++; if (Result !== 32'd0 || Zero !== 1'b1) begin fails++; $display("FAIL div_zero_flag result=%h zero=%b exp 0/1", Result, Zero); end
        tick();
        tests++; if (lo !== 32'd0 || hi !== 32'd3) begin fails++; $display("FAIL div_small hi=%h lo=%h exp 3/0", hi, lo); end
    endtask

    task automatic test_reset_mid();
        set_in(4'd11, 32'd20, 32'd5);
        tick();
        #1 rst = 1'b1;
        #1;
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL async_reset hi=%h lo=%h exp 0/0", hi, lo); end
        set_in(4'd0, 32'd5, 32'hFFFF_FFFB);
        tests++; if (Result !== 32'd0 || Zero !== 1'b1 || Gt !== 1'b1) begin fails++; $display("FAIL reset_comb result=%h zero=%b gt=%b exp 0/1/1", Result, Zero, Gt); end
        rst = 1'b0;
        tick();
        tests++; if (hi !== 32'd0 || lo !== 32'd0 || Zero !== 1'b1) begin fails++; $display("FAIL add_after_reset hi=%h lo=%h zero=%b exp 0/0/1", hi, lo, Zero); end
    endtask

    task automatic test_reset_release();
        rst = 1'b1;
        set_in(4'd11, 32'd20, 32'd5);
        @(posedge clk);
        rst = 1'b0;
        #1;
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL release_edge hi=%h lo=%h exp 0/0", hi, lo); end
        tick();
        tests++; if (hi !== 32'd0 || lo !== 32'd100) begin fails++; $display("FAIL after_release hi=%h lo=%h exp 0/100", hi, lo); end
    endtask

    initial begin
        rst = 1'b1;
        AluCtl = 4'd0;
        A = 32'd0;
        B = 32'd0;
        #12;
        test_reset();
        test_div();
        test_arith();
        test_shift_logic();
        test_mult_madd();
        test_div_corner();
        test_reset_mid();
        test_reset_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  system clock; hi/lo update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  32  operand A (rs).
REQ-005 B  input  32  operand B (rt).
REQ-006 AluCtl  input  4  operation select.
REQ-007 Result  output  32  combinational operation result.
REQ-008 Zero  output  1  high when Result == 0.
REQ-009 Gt  output  1  high when $signed(A) > $signed(B).
REQ-010 hi  output  32  HI register, upper product or remainder.
REQ-011 lo  output  32  LO register, lower product or quotient.

Function
REQ-012 Result, Zero and Gt SHALL be purely combinational from A, B and AluCtl, with zero latency.
REQ-013 AluCtl encoding SHALL be: 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR; 6 SLL; 7 SRL; 8 SRA; 9 SLT; 10 SLTU; 11 MULT; 12 MULTU; 13 MADD; 14 DIV; 15 DIVU.
REQ-014 ADD and SUB SHALL wrap modulo 2^32, with no overflow flag and no trap.
REQ-015 SLL, SRL and SRA SHALL shift A by B[4:0]; SRA sign-fills; B[31:5] ignored.
REQ-016 SLT SHALL give Result = 1 when signed A < signed B, else 0; SLTU does the same unsigned.
REQ-017 MULT and MULTU SHALL compute the 64-bit signed or unsigned product P; next {hi,lo} = P.
REQ-018 MADD SHALL compute next {hi,lo} = {hi,lo} + signed 64-bit A*B, wrapping modulo 2^64.
REQ-019 DIV and DIVU SHALL set next lo = quotient truncated toward zero and next hi = remainder, with the remainder taking the sign of the dividend for DIV.
REQ-020 Divide by zero (B == 0) SHALL set next lo = 0xFFFFFFFF and next hi = A, for both DIV and DIVU.
REQ-021 DIV overflow (A = 0x80000000, B = 0xFFFFFFFF) SHALL set next lo = 0x80000000 and next hi = 0.
REQ-022 For AluCtl 11..15, Result SHALL equal the next lo value, driven combinationally.
REQ-023 hi and lo SHALL load only on a rising clk edge while AluCtl is in 11..15; for all other codes they hold.
REQ-024 All mult/div operations SHALL complete in one cycle with no handshake and no busy signal.
REQ-025 Zero SHALL track Result for every opcode, including 11..15.
REQ-026 Gt SHALL be independent of AluCtl.

Reset
REQ-027 While rst = 1, hi and lo SHALL be forced to 0 immediately, without waiting for clk.
REQ-028 rst SHALL NOT affect the combinational outputs Result, Zero and Gt.
REQ-029 If rst deasserts coincident with a clk edge while a mult/div code is present, that edge SHALL NOT load hi/lo.

Structure
REQ-030 The AluCtl opcode constants (ALU_ADD .. ALU_DIVU) SHALL live in a shared package, alu_pkg, that is also used by the control decoder.
REQ-031 A single sub-module, alu_muldiv, SHALL contain the 64-bit multiply, MADD accumulate and divide logic; all other operations stay in alu.

Verification
REQ-032 A=20, B=5: DIV -> after edge lo=4, hi=0, Result=4, Gt=1; DIVU gives the same; MULT -> lo=100, hi=0.
REQ-033 A=0xFFFFFFEC, B=1: ADD -> 0xFFFFFFED; SUB -> 0xFFFFFFEB; SLT -> 1; SLTU -> 0; Gt=0; Zero=0.
REQ-034 A=0xFFFFFFEC, B=1: SRA -> 0xFFFFFFF6; SRL -> 0x7FFFFFF6; SLL -> 0xFFFFFFD8; NOR -> 0x00000012.
REQ-035 A=0xFFFFFFEC, B=1: MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFEC; MULTU -> hi=0, lo=0xFFFFFFEC; MADD after MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFD8.
REQ-036 B=0 with DIV -> lo=0xFFFFFFFF, hi=A; A=0x80000000, B=0xFFFFFFFF with DIV -> lo=0x80000000, hi=0.
REQ-037 Assert rst mid-sequence between clk edges -> hi=lo=0 at once; then ADD with A=5, B=0xFFFFFFFB -> Result=0, Zero=1, and hi/lo unchanged.
